button_debounce: RTL

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 127 ++++++++++++
 1 files changed

// File: rtl/button_debounce.sv
// Multi-channel pushbutton debouncer: 2-flop synchronizer per channel feeding an
// independent four-state FSM that emits a debounced level and one-cycle press/release pulses.
module button_debounce #(
    parameter int N         = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [N-1:0] pb_in,
    output logic [N-1:0] pb_level,
    output logic [N-1:0] pb_press,
    output logic [N-1:0] pb_release
);

    localparam int CW = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } state_t;

    logic [N-1:0] sync1_q;
    logic [N-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pb_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          sync;

        assign sync = sync2_q[i];

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                RELEASED: begin
                    if (sync) begin
                        state_d = PRESS_PEND;
                        cnt_d   = CW'(1);
                    end else begin
                        cnt_d   = '0;
                    end
                end
                PRESS_PEND: begin
                    if (!sync) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q >= LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!sync) begin
                        state_d = RELEASE_PEND;
                        cnt_d   = CW'(1);
                    end else begin
                        cnt_d   = '0;
                    end
                end
                RELEASE_PEND: begin
                    // Any return to the pressed level cancels the pending release.
                    if (sync) begin
                        state_d   = PRESSED;
                        cnt_d     = '0;
                    end else if (cnt_q >= LAST) begin
                        state_d   = RELEASED;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (!nrst) begin
                state_q   <= RELEASED;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign pb_level[i]   = level_q;
        assign pb_press[i]   = press_q;
        assign pb_release[i] = release_q;
    end

endmodule
